// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
// Holds the request opcode encoding, the FSM state type, big-endian lane
// select helpers and the default data memory depth.
package lsu_pkg;

  localparam int LSU_DEPTH = 128;

  localparam logic [2:0] OP_LBZ = 3'd0;
  localparam logic [2:0] OP_LHZ = 3'd1;
  localparam logic [2:0] OP_LHA = 3'd2;
  localparam logic [2:0] OP_LWZ = 3'd3;
  localparam logic [2:0] OP_STB = 3'd4;
  localparam logic [2:0] OP_STH = 3'd5;
  localparam logic [2:0] OP_STW = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  // Big-endian: byte offset 0 lives in bits 31:24, so the LSB is (3-off)*8.
  function automatic logic [4:0] byte_lsb(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

  // Halfword addr[1]=0 is the upper half (LSB 16), addr[1]=1 the lower half.
  function automatic logic [4:0] half_lsb(input logic hi_sel);
    return {~hi_sel, 4'b0000};
  endfunction

endpackage

// File: rtl/lsu_lane_format.sv
// lsu_lane_format: combinational lane extraction and store merge.
// Produces the extended load value and the read-modify-write merged word
// from one memory word; shared between the load and sub-word store paths.
module lsu_lane_format
  import lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  b_lsb;
  logic [4:0]  h_lsb;
  logic [31:0] b_shift;
  logic [31:0] h_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lanes, then extend or merge according to the op.
  always_comb begin
    b_lsb    = byte_lsb(off_i);
    h_lsb    = half_lsb(off_i[1]);
    b_shift  = word_i >> b_lsb;
    h_shift  = word_i >> h_lsb;
    byte_sel = b_shift[7:0];
    half_sel = h_shift[15:0];
    load_o   = '0;
    merged_o = word_i;
    case (op_i)
      OP_LBZ: load_o = {24'h0, byte_sel};
      OP_LHZ: load_o = {16'h0, half_sel};
      OP_LHA: load_o = {{16{half_sel[15]}}, half_sel};
      OP_LWZ: load_o = word_i;
      OP_STB: merged_o = (word_i & ~(BYTE_MASK << b_lsb)) |
                         ((wdata_i & BYTE_MASK) << b_lsb);
      OP_STH: merged_o = (word_i & ~(HALF_MASK << h_lsb)) |
                         ((wdata_i & HALF_MASK) << h_lsb);
      OP_STW: merged_o = wdata_i;
      default: begin
        load_o   = '0;
        merged_o = word_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit between the MEM stage and word-addressed memory.
// One request at a time; sub-word stores are read-modify-write; loads are
// big-endian extracted and extended; a tagged response returns to writeback.
// Optional macro LSU_ALIGN_CHECK_EN turns misaligned halfword/word accesses
// into errors; without it misaligned accesses are forced aligned.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter  int DEPTH = LSU_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [4:0]       req_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [4:0]       rsp_rd,
  output logic             rsp_err,
  output logic             mem_read_en,
  output logic [IDX_W-1:0] mem_read_addr,
  input  logic [31:0]      mem_read_data,
  output logic             mem_write_en,
  output logic [IDX_W-1:0] mem_write_addr,
  output logic [31:0]      mem_write_data
);

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [1:0]       off_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [4:0]       rd_q;
  logic [31:0]      word_q;
  logic [31:0]      rsp_data_q;
  logic             err_q;

  logic             accept;
  logic             req_err;
  logic [31:0]      load_w;
  logic [31:0]      merged_w;

  assign req_ready = rst_n && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Classify the incoming request as an error before any memory access.
  always_comb begin
    req_err = (req_op == OP_ILL) || (req_addr[31:2] >= 30'(DEPTH));
`ifdef LSU_ALIGN_CHECK_EN
    if ((req_op == OP_LHZ || req_op == OP_LHA || req_op == OP_STH) && req_addr[0])
      req_err = 1'b1;
    if ((req_op == OP_LWZ || req_op == OP_STW) && (req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  // Next-state decode for the single-outstanding-request sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                 state_d = S_RESP;
          else if (req_op <= OP_LWZ)   state_d = S_RD;
          else if (req_op == OP_STW)   state_d = S_WR;
          else                         state_d = S_RMW_RD;
        end
      end
      S_RD:     state_d = S_RESP;
      S_RMW_RD: state_d = S_WR;
      S_WR:     state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Latched request fields, merged store word and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      off_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      word_q     <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= req_op;
        off_q      <= req_addr[1:0];
        idx_q      <= req_addr[IDX_W+1:2];
        wdata_q    <= req_wdata;
        rd_q       <= req_rd;
        word_q     <= req_wdata;
        rsp_data_q <= '0;
        err_q      <= req_err;
      end
      if (state_q == S_RD)     rsp_data_q <= load_w;
      if (state_q == S_RMW_RD) word_q     <= merged_w;
    end
  end

  lsu_lane_format u_fmt (
    .op_i     (op_q),
    .off_i    (off_q),
    .word_i   (mem_read_data),
    .wdata_i  (wdata_q),
    .load_o   (load_w),
    .merged_o (merged_w)
  );

  assign mem_read_en    = rst_n && ((state_q == S_RD) || (state_q == S_RMW_RD));
  assign mem_read_addr  = mem_read_en  ? idx_q  : '0;
  assign mem_write_en   = rst_n && (state_q == S_WR);
  assign mem_write_addr = mem_write_en ? idx_q  : '0;
  assign mem_write_data = mem_write_en ? word_q : '0;

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rd_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: self-checking bench for lsu_mem_if with a byte-array
// reference model of big-endian memory.
module tb_lsu_mem_if;

  localparam int DEPTH = 128;
  localparam int IDX_W = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [4:0]       req_rd;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [4:0]       rsp_rd;
  logic             rsp_err;
  logic             mem_read_en;
  logic [IDX_W-1:0] mem_read_addr;
  logic [31:0]      mem_read_data;
  logic             mem_write_en;
  logic [IDX_W-1:0] mem_write_addr;
  logic [31:0]      mem_write_data;

  logic [31:0] mem [DEPTH];
  logic [7:0]  ref_bytes [DEPTH*4];

  int nasrt = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_read_addr];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
  end

  lsu_mem_if #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_rd         (req_rd),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_rd         (rsp_rd),
    .rsp_err        (rsp_err),
    .mem_read_en    (mem_read_en),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data)
  );

  function automatic logic [31:0] ref_word(input logic [6:0] idx);
    int a;
    a = int'(idx) * 4;
    return {ref_bytes[a], ref_bytes[a+1], ref_bytes[a+2], ref_bytes[a+3]};
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    mem[idx] = val;
    ref_bytes[idx*4]   = val[31:24];
    ref_bytes[idx*4+1] = val[23:16];
    ref_bytes[idx*4+2] = val[15:8];
    ref_bytes[idx*4+3] = val[7:0];
  endtask

  // Reference: memory is a flat big-endian byte array.
  task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] data,
                       output int lat, output int nrd, output int nwr);
    int b, h, w;
    logic [15:0] hv;
    b = int'(addr[8:0]);
    h = b - (b % 2);
    w = b - (b % 4);
    err = (op == 3'd7) || (addr[31:2] >= 30'(DEPTH));
`ifdef LSU_ALIGN_CHECK_EN
    if ((op == 3'd1 || op == 3'd2 || op == 3'd5) && (b % 2 != 0)) err = 1'b1;
    if ((op == 3'd3 || op == 3'd6) && (b % 4 != 0)) err = 1'b1;
`endif
    data = 32'h0; lat = 1; nrd = 0; nwr = 0;
    if (!err) begin
      case (op)
        3'd0: begin data = {24'h0, ref_bytes[b]}; lat = 2; nrd = 1; end
        3'd1, 3'd2: begin
          hv = {ref_bytes[h], ref_bytes[h+1]};
          data = (op == 3'd2) ? {{16{hv[15]}}, hv} : {16'h0, hv};
          lat = 2; nrd = 1;
        end
        3'd3: begin
          data = {ref_bytes[w], ref_bytes[w+1], ref_bytes[w+2], ref_bytes[w+3]};
          lat = 2; nrd = 1;
        end
        3'd4: begin ref_bytes[b] = wdata[7:0]; lat = 3; nrd = 1; nwr = 1; end
        3'd5: begin
          ref_bytes[h] = wdata[15:8]; ref_bytes[h+1] = wdata[7:0];
          lat = 3; nrd = 1; nwr = 1;
        end
        default: begin
          ref_bytes[w] = wdata[31:24]; ref_bytes[w+1] = wdata[23:16];
          ref_bytes[w+2] = wdata[15:8]; ref_bytes[w+3] = wdata[7:0];
          lat = 2; nwr = 1;
        end
      endcase
    end
  endtask

  // Issue one request from a negedge; returns at a negedge.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
    logic        e;
    logic [31:0] d, ww;
    logic [6:0]  idx;
    int lat_e, rd_e, wr_e, lat, nrd, nwr;
    model(op, addr, wdata, e, d, lat_e, rd_e, wr_e);
    idx = addr[8:2];
    ww  = ref_word(idx);
    req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
    nasrt++;
    if (req_ready !== 1'b1) begin
      nfail++; $display("FAIL req_ready op=%0d addr=%h got %b want 1", op, addr, req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      if (mem_read_en === 1'b1) begin
        nrd++;
        nasrt++;
        if (mem_read_addr !== idx) begin
          nfail++; $display("FAIL rd_addr op=%0d got %h want %h", op, mem_read_addr, idx);
        end
      end
      if (mem_write_en === 1'b1) begin
        nwr++;
        nasrt++;
        if (mem_write_addr !== idx || mem_write_data !== ww) begin
          nfail++; $display("FAIL wr op=%0d got %h/%h want %h/%h", op, mem_write_addr,
                            mem_write_data, idx, ww);
        end
      end else begin
        nasrt++;
        if (mem_write_addr !== '0 || mem_write_data !== '0) begin
          nfail++; $display("FAIL wr_idle_zero got %h/%h want 0/0", mem_write_addr, mem_write_data);
        end
      end
      @(negedge clk);
      lat++;
    end
    nasrt++;
    if (lat !== lat_e) begin
      nfail++; $display("FAIL latency op=%0d addr=%h got %0d want %0d", op, addr, lat, lat_e);
    end
    nasrt++;
    if (nrd !== rd_e || nwr !== wr_e) begin
      nfail++; $display("FAIL access_count op=%0d got r%0d w%0d want r%0d w%0d", op, nrd, nwr, rd_e, wr_e);
    end
    nasrt++;
    if (rsp_data !== d || rsp_err !== e || rsp_rd !== rd) begin
      nfail++; $display("FAIL rsp op=%0d addr=%h got %h/%b/%0d want %h/%b/%0d", op, addr,
                        rsp_data, rsp_err, rsp_rd, d, e, rd);
    end
    nasrt++;
    if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
      nfail++; $display("FAIL resp_en got r%b w%b want 0 0", mem_read_en, mem_write_en);
    end
    if (rsp_ready) begin
      @(posedge clk);
      @(negedge clk);
      if (!e) begin
        nasrt++;
        if (mem[idx] !== ref_word(idx)) begin
          nfail++; $display("FAIL mem_word idx=%0d got %h want %h", idx, mem[idx], ref_word(idx));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    @(posedge clk);
    @(negedge clk);
    nasrt++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 ||
        rsp_rd !== 5'd0 || rsp_err !== 1'b0) begin
      nfail++; $display("FAIL reset_outputs got rdy=%b v=%b d=%h rd=%0d e=%b want 0", req_ready,
                        rsp_valid, rsp_data, rsp_rd, rsp_err);
    end
    nasrt++;
    if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
      nfail++; $display("FAIL reset_mem_en got r%b w%b want 0 0", mem_read_en, mem_write_en);
    end
    rst_n = 1'b1;
    #1;
    nasrt++;
    if (req_ready !== 1'b1) begin
      nfail++; $display("FAIL reset_release_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_plan_loads();
    @(negedge clk);
    preload(3, 32'h8899AABB);
    do_req(3'd0, 32'd13, 32'h0, 5'd7);
    nasrt++;
    if (rsp_data !== 32'h00000099) begin
      nfail++; $display("FAIL lbz13 got %h want 00000099", rsp_data);
    end
    do_req(3'd2, 32'd12, 32'h0, 5'd9);
    do_req(3'd1, 32'd14, 32'h0, 5'd11);
  endtask

  task automatic test_plan_stores();
    @(negedge clk);
    do_req(3'd4, 32'd14, 32'h11, 5'd3);
    nasrt++;
    if (mem[3] !== 32'h889911BB) begin
      nfail++; $display("FAIL stb14 got %h want 889911BB", mem[3]);
    end
    do_req(3'd6, 32'd8, 32'hDEADBEEF, 5'd4);
    nasrt++;
    if (mem[2] !== 32'hDEADBEEF) begin
      nfail++; $display("FAIL stw8 got %h want DEADBEEF", mem[2]);
    end
    do_req(3'd3, 32'd8, 32'h0, 5'd5);
    do_req(3'd5, 32'd22, 32'hCAFE1234, 5'd6);
  endtask

  task automatic test_errors();
    @(negedge clk);
    do_req(3'd3, 32'h201, 32'h0, 5'd1);
    do_req(3'd3, 32'd512, 32'h0, 5'd2);
    do_req(3'd7, 32'd4, 32'h0, 5'd3);
    do_req(3'd6, 32'hFFFF_FFF0, 32'h1234, 5'd4);
    do_req(3'd1, 32'd13, 32'h0, 5'd5);
  endtask

  task automatic test_backpressure();
    logic [31:0] d0;
    logic [4:0]  r0;
    logic        e0;
    @(negedge clk);
    rsp_ready = 1'b0;
    do_req(3'd3, 32'd12, 32'h0, 5'd21);
    d0 = rsp_data; r0 = rsp_rd; e0 = rsp_err;
    req_op = 3'd0; req_addr = 32'd16; req_rd = 5'd22; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nasrt++;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_rd !== r0 || rsp_err !== e0 ||
          req_ready !== 1'b0) begin
        nfail++; $display("FAIL hold cyc=%0d got v=%b d=%h rd=%0d rdy=%b want 1/%h/%0d/0", i,
                          rsp_valid, rsp_data, rsp_rd, req_ready, d0, r0);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    nasrt++;
    if (rsp_valid !== 1'b0) begin
      nfail++; $display("FAIL release_taken got %b want 0", rsp_valid);
    end
    do_req(3'd0, 32'd16, 32'h0, 5'd22);
  endtask

  task automatic test_reset_in_wr();
    logic [31:0] saved;
    @(negedge clk);
    saved = mem[1];
    req_op = 3'd5; req_addr = 32'd4; req_wdata = 32'h5A5A; req_rd = 5'd9; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    nasrt++;
    if (mem_write_en !== 1'b1) begin
      nfail++; $display("FAIL rst_wr_state got %b want 1", mem_write_en);
    end
    rst_n = 1'b0;
    #1;
    nasrt++;
    if (mem_write_en !== 1'b0) begin
      nfail++; $display("FAIL rst_wr_gate got %b want 0", mem_write_en);
    end
    @(posedge clk);
    @(negedge clk);
    nasrt++;
    if (mem[1] !== saved) begin
      nfail++; $display("FAIL rst_wr_mem got %h want %h", mem[1], saved);
    end
    nasrt++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_rd !== 5'd0 || rsp_err !== 1'b0 ||
        req_ready !== 1'b0) begin
      nfail++; $display("FAIL rst_wr_outputs got v=%b d=%h rd=%0d e=%b rdy=%b want 0", rsp_valid,
                        rsp_data, rsp_rd, rsp_err, req_ready);
    end
    rst_n = 1'b1;
    #1;
    nasrt++;
    if (req_ready !== 1'b1) begin
      nfail++; $display("FAIL rst_wr_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    @(negedge clk);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = {23'h0, 7'($urandom_range(0, DEPTH-1)), 2'($urandom_range(0, 3))};
      do_req(3'($urandom_range(0, 7)), a, $urandom, 5'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
    test_reset();
    test_plan_loads();
    test_plan_stores();
    test_errors();
    test_backpressure();
    test_reset_in_wr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
